// File: rtl/h264_dc_transform.sv
// h264_dc_transform: 2x2 Hadamard (DC) transform for H.264 chroma DC.
//
// Four signed 16-bit DC values arrive serially (x3 first, x0 last) under
// READYI/ENABLE. One CALC cycle forms the four 18-bit Hadamard sums. The
// results stream out (y3 first, y0 last) under VALID/READYO.
//
// Ports:
//   CLK     in   clock, rising edge
//   RESET   in   asynchronous, active-high reset
//   READYI  out  block can accept an input this cycle
//   ENABLE  in   XXIN valid this cycle
//   XXIN    in   signed 16-bit input value
//   VALID   out  YYOUT valid this cycle
//   YYOUT   out  signed 16-bit output value
//   READYO  in   downstream ready
//
// Parameter TOGETHER: 0 = one output per READYO=1 edge,
//                     1 = first READYO=1 starts an unbroken 4-cycle burst.
// Macro DC_TRANSFORM_SATURATE_EN: when defined, each 18-bit result is
// clamped to [-32768, 32767]. When undefined, the low 16 bits pass (wrap).

// Per-lane narrowing of an 18-bit sum to the 16-bit output width.
module h264_dc_narrow (
  input  logic signed [17:0] din,
  output logic        [15:0] dout
);
`ifdef DC_TRANSFORM_SATURATE_EN
  always_comb begin
    if (din > 18'sd32767)        dout = 16'h7FFF;
    else if (din < -18'sd32768)  dout = 16'h8000;
    else                         dout = din[15:0];
  end
`else
  logic [1:0] unused_hi;
  assign unused_hi = din[17:16];
  assign dout      = din[15:0];
`endif
endmodule

module h264_dc_transform #(
  parameter int TOGETHER = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        READYI,
  input  logic        ENABLE,
  input  logic [15:0] XXIN,
  output logic        VALID,
  output logic [15:0] YYOUT,
  input  logic        READYO
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] in_cnt_q, in_cnt_d;
  logic [1:0] out_cnt_q, out_cnt_d;
  logic       readyi_q, readyi_d;
  logic       valid_q, valid_d;
  logic       burst_q, burst_d;
  logic [VEC_W-1:0] yyout_q, yyout_d;
  // x_q[0] holds x3 (first in); y_q[0] holds y3 (first out).
  logic [NUM_LANES-1:0][VEC_W-1:0] x_q, x_d;
  logic [NUM_LANES-1:0][VEC_W-1:0] y_q, y_d;

  // Butterfly on sign-extended inputs. 18 bits hold a sum of four 16-bit values.
  logic signed [17:0] x0, x1, x2, x3, s01, d01, s23, d23;
  logic signed [17:0] ysum [NUM_LANES];
  logic [NUM_LANES-1:0][VEC_W-1:0] ynar;

  assign x0  = {{2{x_q[3][15]}}, x_q[3]};
  assign x1  = {{2{x_q[2][15]}}, x_q[2]};
  assign x2  = {{2{x_q[1][15]}}, x_q[1]};
  assign x3  = {{2{x_q[0][15]}}, x_q[0]};
  assign s01 = x0 + x1;
  assign d01 = x0 - x1;
  assign s23 = x2 + x3;
  assign d23 = x2 - x3;

  // Lane order matches output order: lane 0 = y3 ... lane 3 = y0.
  assign ysum[0] = d01 - d23;  // y3 = x0-x1-x2+x3
  assign ysum[1] = s01 - s23;  // y2 = x0+x1-x2-x3
  assign ysum[2] = d01 + d23;  // y1 = x0-x1+x2-x3
  assign ysum[3] = s01 + s23;  // y0 = x0+x1+x2+x3

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      h264_dc_narrow u_narrow (.din(ysum[g]), .dout(ynar[g]));
    end
  endgenerate

  logic advance;
  // A started burst keeps running in TOGETHER mode regardless of READYO.
  assign advance = READYO || ((TOGETHER != 0) && burst_q);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    readyi_d  = readyi_q;
    valid_d   = valid_q;
    burst_d   = burst_q;
    yyout_d   = yyout_q;
    x_d       = x_q;
    y_d       = y_q;
    case (state_q)
      S_IDLE: begin
        // READYI comes up on the first edge after reset or output drain.
        readyi_d = 1'b1;
        valid_d  = 1'b0;
        if (ENABLE && readyi_q) begin
          x_d[in_cnt_q] = XXIN;
          in_cnt_d      = in_cnt_q + 2'd1;
          if (in_cnt_q == 2'd3) begin
            readyi_d = 1'b0;
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        y_d       = ynar;
        out_cnt_d = 2'd0;
        valid_d   = 1'b0;
        state_d   = S_OUT;
      end
      S_OUT: begin
        if (advance) begin
          yyout_d   = y_q[out_cnt_q];
          valid_d   = 1'b1;
          burst_d   = 1'b1;
          out_cnt_d = out_cnt_q + 2'd1;
          if (out_cnt_q == 2'd3) begin
            burst_d  = 1'b0;
            readyi_d = 1'b1;
            state_d  = S_IDLE;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        valid_d  = 1'b0;
        readyi_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      in_cnt_q  <= 2'd0;
      out_cnt_q <= 2'd0;
      readyi_q  <= 1'b0;
      valid_q   <= 1'b0;
      burst_q   <= 1'b0;
      yyout_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      readyi_q  <= readyi_d;
      valid_q   <= valid_d;
      burst_q   <= burst_d;
      yyout_q   <= yyout_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign READYI = readyi_q;
  assign VALID  = valid_q;
  assign YYOUT  = yyout_q;
endmodule

// File: tb/tb_h264_dc_transform.sv
// Directed bench for h264_dc_transform. dut0 runs TOGETHER=0, dut1 runs
// TOGETHER=1. They share RESET/ENABLE/XXIN and have separate READYO inputs.
module tb_h264_dc_transform;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic [15:0] XXIN = '0;
  logic        READYO0 = 1'b0, READYO1 = 1'b0;
  logic        READYI0, READYI1, VALID0, VALID1;
  logic [15:0] YYOUT0, YYOUT1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  h264_dc_transform #(.TOGETHER(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .READYI(READYI0), .ENABLE(ENABLE), .XXIN(XXIN),
    .VALID(VALID0), .YYOUT(YYOUT0), .READYO(READYO0));

  h264_dc_transform #(.TOGETHER(1)) dut1 (
    .CLK(CLK), .RESET(RESET), .READYI(READYI1), .ENABLE(ENABLE), .XXIN(XXIN),
    .VALID(VALID1), .YYOUT(YYOUT1), .READYO(READYO1));

  // x[0] is fed first (x3); y[0] is expected first (y3).
  typedef struct packed {
    logic [3:0][15:0] x;
    logic [3:0][15:0] y;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input logic [15:0] x3, x2, x1, x0,
                              input logic [15:0] y3, y2, y1, y0);
    vec_t v;
    v.x[0] = x3; v.x[1] = x2; v.x[2] = x1; v.x[3] = x0;
    v.y[0] = y3; v.y[1] = y2; v.y[2] = y1; v.y[3] = y0;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit chk);
    RESET = 1'b1;
    step();
    step();
    if (chk) begin
      check("rst_readyi", READYI0, 0);
      check("rst_valid", VALID0, 0);
      check("rst_yyout", YYOUT0, 0);
      check("rst_valid_t1", VALID1, 0);
    end
    RESET = 1'b0;
    if (chk) check("rst_readyi_release", READYI0, 0);
    step();
    if (chk) begin
      check("rst_readyi_rise", READYI0, 1);
      check("rst_valid_after", VALID0, 0);
      check("rst_yyout_after", YYOUT0, 0);
    end
  endtask

  // Feed v[lo..hi], waiting (bounded) for READYI before each accepting edge.
  task automatic load(input logic [3:0][15:0] v, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      int n;
      n = 0;
      ENABLE = 1'b1;
      XXIN = v[i];
      while (!READYI0 && n < 20) begin
        step();
        n++;
      end
      check("load_readyi_wait", READYI0, 1);
      step();
    end
    ENABLE = 1'b0;
  endtask

  // Called just after the edge that accepted x0, with READYO0 held at 1.
  // The caller ends on the cycle where y0 is on YYOUT and READYI is back.
  task automatic expect_block(input logic [3:0][15:0] y, input string tag);
    check({tag, "_readyi_low"}, READYI0, 0);
    step();
    check({tag, "_calc_novalid"}, VALID0, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("%s_valid%0d", tag, i), VALID0, 1);
      check($sformatf("%s_y%0d", tag, 3 - i), YYOUT0, y[i]);
    end
    check({tag, "_readyi_back"}, READYI0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pat [7];
    int nv;
    logic [15:0] last;
    vec_t v;

    tbl[0] = mk(16'd4, 16'd3, 16'd2, 16'd1, 16'h0000, 16'hFFFC, 16'hFFFE, 16'h000A);
    tbl[1] = mk(16'd100, 16'd100, 16'd100, 16'd100, 16'h0000, 16'h0000, 16'h0000, 16'h0190);
    tbl[2] = mk(16'd10, 16'hFFFB, 16'd7, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFE7, 16'h0009);
`ifdef DC_TRANSFORM_SATURATE_EN
    tbl[3] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF);
    tbl[4] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000);
    tbl[5] = mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h8000, 16'hFFFE);
`else
    tbl[3] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFC);
    tbl[4] = mk(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[5] = mk(16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0002, 16'hFFFE);
`endif

    // Reset release and table-driven vectors, READYO held high.
    do_reset(1'b1);
    READYO0 = 1'b1;
    READYO1 = 1'b1;
    for (int t = 0; t < 6; t++) begin
      load(tbl[t].x, 0, 3);
      expect_block(tbl[t].y, $sformatf("vec%0d", t));
      step();
      check($sformatf("vec%0d_valid_end", t), VALID0, 0);
    end

    // Backpressure: READYO 1,0,0,1,1,0,1 from the first OUT edge.
    do_reset(1'b0);
    READYO0 = 1'b0;
    load(tbl[0].x, 0, 3);
    step();
    pat = '{1, 0, 0, 1, 1, 0, 1};
    nv = 0;
    last = '0;
    for (int k = 0; k < 7; k++) begin
      READYO0 = pat[k][0];
      step();
      check($sformatf("bp_valid%0d", k), VALID0, pat[k][0]);
      if (VALID0) begin
        if (nv < 4) check($sformatf("bp_y%0d", 3 - nv), YYOUT0, tbl[0].y[nv]);
        last = YYOUT0;
        nv++;
      end else if (nv > 0) begin
        check($sformatf("bp_hold%0d", k), YYOUT0, last);
      end
    end
    READYO0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_valid_tail", VALID0, 0);
    end
    check("bp_count", nv, 4);
    check("bp_readyi", READYI0, 1);

    // Burst mode: one-cycle READYO pulse yields four contiguous outputs.
    do_reset(1'b0);
    READYO0 = 1'b1;
    READYO1 = 1'b0;
    load(tbl[1].x, 0, 3);
    step();
    step();
    check("burst_wait_novalid", VALID1, 0);
    READYO1 = 1'b1;
    step();
    READYO1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_valid%0d", i), VALID1, 1);
      check($sformatf("burst_y%0d", 3 - i), YYOUT1, tbl[1].y[i]);
      step();
    end
    check("burst_valid_end", VALID1, 0);
    check("burst_readyi", READYI1, 1);

    // Reset after two inputs, then a fresh block must decode alone.
    do_reset(1'b0);
    READYO0 = 1'b1;
    READYO1 = 1'b1;
    v = mk(16'd9, 16'd9, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    load(v.x, 0, 1);
    do_reset(1'b0);
    load(tbl[0].x, 0, 3);
    expect_block(tbl[0].y, "midload");
    step();

    // Reset during output: VALID must drop asynchronously.
    load(tbl[2].x, 0, 3);
    step();
    step();
    check("midout_valid", VALID0, 1);
    #2;
    RESET = 1'b1;
    #1;
    check("midout_async_valid", VALID0, 0);
    check("midout_async_yyout", YYOUT0, 0);
    check("midout_async_readyi", READYI0, 0);
    do_reset(1'b0);

    // ENABLE held high while READYI=0 is ignored; ENABLE on the READYI
    // re-assert cycle loads x3 of the next block.
    load(tbl[0].x, 0, 3);
    ENABLE = 1'b1;
    XXIN = 16'h7777;
    expect_block(tbl[0].y, "enhold");
    XXIN = 16'd5;
    step();
    check("enhold_valid_end", VALID0, 0);
    v = mk(16'd5, 16'd0, 16'd0, 16'd0, 16'h0005, 16'hFFFB, 16'hFFFB, 16'h0005);
    load(v.x, 1, 3);
    expect_block(v.y, "reassert");
    step();
    check("reassert_valid_end", VALID0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
